// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi-channel stopwatch/countdown engine:
//   - ch_state_t   : channel state encoding (IDLE/RUN/PAUSED/DONE)
//   - LIM_*        : largest legal value of a BCD digit (9 or 5)
//   - IDX_*        : digit positions inside a 24-bit {Ht,Ho,Mt,Mo,St,So} word
//   - bcd_inc6     : add one second to an HH:MM:SS BCD word
//   - bcd_dec6     : subtract one second from an HH:MM:SS BCD word
//   - bcd_valid    : every digit within its limit
// ----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_t;

    localparam logic [3:0] LIM_NINE = 4'd9;
    localparam logic [3:0] LIM_FIVE = 4'd5;

    // Digit index 0 is the least significant nibble (seconds ones).
    localparam int IDX_SO = 0;
    localparam int IDX_ST = 1;
    localparam int IDX_MO = 2;
    localparam int IDX_MT = 3;
    localparam int IDX_HO = 4;
    localparam int IDX_HT = 5;

    localparam logic [23:0] HMS_MAX  = 24'h995959;
    localparam logic [23:0] HMS_ZERO = 24'h000000;

    // Tens-of-minutes and tens-of-seconds roll over at 5, everything else at 9.
    function automatic logic [3:0] digit_limit(input int idx);
        logic [3:0] lim;
        case (idx)
            IDX_SO, IDX_MO, IDX_HO, IDX_HT: lim = LIM_NINE;
            IDX_ST, IDX_MT:                 lim = LIM_FIVE;
            default:                        lim = LIM_NINE;
        endcase
        return lim;
    endfunction

    // Ripple a +1 through the six digits; a digit at its limit wraps to 0
    // and passes the carry on.
    function automatic logic [23:0] bcd_inc6(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = v[i*4 +: 4];
            if (carry) begin
                if (d >= digit_limit(i)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple a -1 through the six digits; a zero digit borrows and becomes
    // its limit.
    function automatic logic [23:0] bcd_dec6(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = v[i*4 +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[i*4 +: 4] = digit_limit(i);
                end else begin
                    r[i*4 +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v[i*4 +: 4] > digit_limit(i)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/multi_timer_core_if.sv
// ----------------------------------------------------------------------------
// multi_timer_core_if
// Command and display bundle of the multi-channel timer.
//   master : ch_sel, start, pause, clear, mode, load_valid, load_hms (drives)
//            load_ready, load_err, disp_*, running, expired, one_sec (reads)
//   slave  : the timer core, opposite directions
// ----------------------------------------------------------------------------
interface multi_timer_core_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   ch_sel;
    logic              start;
    logic              pause;
    logic              clear;
    logic              mode;
    logic              load_valid;
    logic [23:0]       load_hms;
    logic              load_ready;
    logic              load_err;
    logic [23:0]       disp_bcd;
    logic [1:0]        disp_state;
    logic              disp_mode;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] expired;
    logic              one_sec;

    modport master (
        output ch_sel, start, pause, clear, mode, load_valid, load_hms,
        input  load_ready, load_err, disp_bcd, disp_state, disp_mode,
               running, expired, one_sec
    );

    modport slave (
        input  ch_sel, start, pause, clear, mode, load_valid, load_hms,
        output load_ready, load_err, disp_bcd, disp_state, disp_mode,
               running, expired, one_sec
    );

endinterface

// File: rtl/timer_channel.sv
// ----------------------------------------------------------------------------
// timer_channel
// One BCD HH:MM:SS stopwatch/countdown channel with its own preset and mode.
//   clk, rst    : clock, asynchronous active-high reset
//   tick        : one-second pulse from the shared prescaler
//   cmd_*       : already prioritised and addressed commands (one at a time)
//   mode_in     : direction latched on start from IDLE (1 = count down)
//   load_hms    : preset value, only presented when the load is legal
//   state, count, mode, expired : channel registers
// ----------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        cmd_clear,
    input  logic        cmd_load,
    input  logic        cmd_start,
    input  logic        cmd_pause,
    input  logic        mode_in,
    input  logic [23:0] load_hms,
    output ch_state_t   state,
    output logic [23:0] count,
    output logic        mode,
    output logic        expired
);

    ch_state_t   state_n;
    logic [23:0] count_n;
    logic [23:0] preset;
    logic [23:0] preset_n;
    logic        mode_n;
    logic        expired_n;

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            preset  <= '0;
            mode    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            preset  <= preset_n;
            mode    <= mode_n;
            expired <= expired_n;
        end
    end

    // The tick is evaluated first from the current state, then commands
    // override it. This lets a pause keep the tick of its own cycle, while a
    // start from PAUSED sees no tick because the channel was not RUN yet.
    always_comb begin
        state_n   = state;
        count_n   = count;
        preset_n  = preset;
        mode_n    = mode;
        expired_n = expired;

        if (tick && state == ST_RUN) begin
            if (!mode) begin
                if (count == HMS_MAX) begin
                    state_n   = ST_DONE;
                    expired_n = 1'b1;
                end else begin
                    count_n = bcd_inc6(count);
                    if (count_n == HMS_MAX) begin
                        state_n   = ST_DONE;
                        expired_n = 1'b1;
                    end
                end
            end else begin
                if (count == HMS_ZERO) begin
                    state_n   = ST_DONE;
                    expired_n = 1'b1;
                end else begin
                    count_n = bcd_dec6(count);
                    if (count_n == HMS_ZERO) begin
                        state_n   = ST_DONE;
                        expired_n = 1'b1;
                    end
                end
            end
        end

        if (cmd_clear) begin
            state_n   = ST_IDLE;
            count_n   = preset;
            expired_n = 1'b0;
        end else if (cmd_load) begin
            if (state == ST_IDLE) begin
                preset_n = load_hms;
                count_n  = load_hms;
            end
        end else if (cmd_start) begin
            case (state)
                ST_IDLE: begin
                    mode_n = mode_in;
                    // A countdown from zero has nothing to count.
                    if (mode_in && count == HMS_ZERO) begin
                        state_n   = ST_DONE;
                        expired_n = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
                ST_PAUSED: state_n = ST_RUN;
                default:   state_n = state_n;
            endcase
        end else if (cmd_pause) begin
            // Only pause if this cycle's tick did not already finish the run.
            if (state == ST_RUN && state_n == ST_RUN) begin
                state_n = ST_PAUSED;
            end
        end
    end

endmodule

// File: rtl/multi_timer_core.sv
// ----------------------------------------------------------------------------
// multi_timer_core
// NUM_CH independent BCD stopwatch/countdown channels sharing a 1 Hz
// prescaler, with a ch_sel-addressed command port and a registered display.
//   clk_100MHz : system clock
//   reset      : asynchronous active-high reset
//   bus        : command/display bundle (slave side)
//                commands act on channel ch_sel only, priority
//                clear > load_valid > start > pause
// ----------------------------------------------------------------------------
module multi_timer_core
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int NUM_CH = 4
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    multi_timer_core_if.slave bus
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0]  pre_cnt;
    logic              one_sec_q;

    ch_state_t         ch_state [NUM_CH];
    logic [23:0]       ch_count [NUM_CH];
    logic [NUM_CH-1:0] ch_mode;
    logic [NUM_CH-1:0] ch_expired;
    logic [NUM_CH-1:0] running_vec;

    logic              sel_ok;
    ch_state_t         sel_state;
    logic [23:0]       sel_count;
    logic              sel_mode;
    logic              load_ok;
    logic              load_reject;
    logic              do_clear;
    logic              do_load;
    logic              do_start;
    logic              do_pause;

    // Free-running prescaler; one_sec is the registered wrap indication, so
    // it is high during the cycle after the counter sat at CLK_HZ-1.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pre_cnt   <= '0;
            one_sec_q <= 1'b0;
        end else begin
            one_sec_q <= (pre_cnt == PRE_LAST);
            pre_cnt   <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // Selected-channel view and command decode. Only the highest-priority
    // command present acts, even when that command is a rejected load.
    always_comb begin
        sel_ok    = (int'(bus.ch_sel) < NUM_CH);
        sel_state = ST_IDLE;
        sel_count = '0;
        sel_mode  = 1'b0;
        if (sel_ok) begin
            sel_state = ch_state[bus.ch_sel];
            sel_count = ch_count[bus.ch_sel];
            sel_mode  = ch_mode[bus.ch_sel];
        end
        load_ok     = sel_ok && (sel_state == ST_IDLE) && bcd_valid(bus.load_hms);
        do_clear    = bus.clear;
        do_load     = !bus.clear && bus.load_valid && load_ok;
        load_reject = !bus.clear && bus.load_valid && !load_ok;
        do_start    = !bus.clear && !bus.load_valid && bus.start;
        do_pause    = !bus.clear && !bus.load_valid && !bus.start && bus.pause;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = sel_ok && (bus.ch_sel == CH_W'(i));

        timer_channel u_channel (
            .clk       (clk_100MHz),
            .rst       (reset),
            .tick      (one_sec_q),
            .cmd_clear (hit && do_clear),
            .cmd_load  (hit && do_load),
            .cmd_start (hit && do_start),
            .cmd_pause (hit && do_pause),
            .mode_in   (bus.mode),
            .load_hms  (bus.load_hms),
            .state     (ch_state[i]),
            .count     (ch_count[i]),
            .mode      (ch_mode[i]),
            .expired   (ch_expired[i])
        );

        assign running_vec[i] = (ch_state[i] == ST_RUN);
    end

    // Registered display of the addressed channel and the load-reject pulse.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            bus.disp_bcd   <= '0;
            bus.disp_state <= ST_IDLE;
            bus.disp_mode  <= 1'b0;
            bus.load_err   <= 1'b0;
        end else begin
            bus.disp_bcd   <= sel_count;
            bus.disp_state <= sel_state;
            bus.disp_mode  <= sel_mode;
            bus.load_err   <= load_reject;
        end
    end

    assign bus.load_ready = sel_ok && (sel_state == ST_IDLE);
    assign bus.running    = running_vec;
    assign bus.expired    = ch_expired;
    assign bus.one_sec    = one_sec_q;

endmodule

// File: doc/multi_timer_core.md
Name: multi_timer_core

Overview:
Parametrised N-channel stopwatch/countdown engine that replaces the single-channel timer behind the VGA clock display. It provides one shared 1 Hz prescaler and NUM_CH independent BCD HH:MM:SS channels, each with its own state machine and countdown preset. A ch_sel-addressed command interface drives the channels, and one registered digit bus feeds the pixel generator.

Parameters:
CLK_HZ, 100000000, input clock frequency; the tick period is CLK_HZ cycles (benches use 10).
NUM_CH, 4, number of timer channels (1..16).
CH_W, $clog2(NUM_CH) with a minimum of 1, localparam width of the channel select.

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous active-high reset
ch_sel  in  CH_W  channel addressed by commands and by the display
start  in  1  one-cycle pulse, synchronised upstream
pause  in  1  one-cycle pulse
clear  in  1  one-cycle pulse
mode  in  1  0 = count up, 1 = count down; sampled on start from IDLE
load_valid  in  1  preset write strobe
load_hms  in  24  BCD preset, ordered {Ht, Ho, Mt, Mo, St, So}
load_ready  out  1  high when the addressed channel is IDLE
load_err  out  1  one-cycle pulse when a load is rejected
disp_bcd  out  24  registered digits of the addressed channel
disp_state  out  2  registered state of the addressed channel
disp_mode  out  1  registered mode of the addressed channel
running  out  NUM_CH  per-channel state==RUN
expired  out  NUM_CH  sticky per-channel done flag
one_sec  out  1  prescaler tick pulse

Behaviour:
- Reset (asynchronous): prescaler 0, one_sec 0, every channel IDLE, count 0, preset 0, mode 0, expired 0, disp_* 0, load_err 0.
- Prescaler: free-running counter 0..CLK_HZ-1.
  - one_sec is registered and high for the one cycle after the counter reaches CLK_HZ-1.
  - The prescaler is never restarted by commands, so the first tick after start arrives within 1..CLK_HZ cycles.
- Channel states (package encoding): IDLE=0, RUN=1, PAUSED=2, DONE=3.
- Commands act on channel ch_sel only. Priority: clear > load_valid > start > pause. Only the highest-priority command present in a cycle acts.
- IDLE:
  - start latches mode, then goes to RUN.
  - If mode=1 and count==00:00:00, start goes directly to DONE and sets expired on the same edge.
- RUN: pause goes to PAUSED.
- PAUSED: start goes to RUN; pause has no effect.
- DONE: start and pause are ignored.
- clear, from any state: IDLE, count <= preset, expired <= 0.
- Load:
  - Accepted only when the addressed channel is IDLE and every digit is valid: Ho/Mo/So <= 9, Mt/St <= 5, Ht <= 9.
  - On accept, preset and count <= load_hms.
  - Otherwise load_err pulses for 1 cycle and nothing changes.
  - load_ready is combinational from the addressed channel's state.
- Tick: applied to every channel whose state was RUN at the start of the cycle.
  - A pause in the same cycle still counts that tick.
  - A start in the same cycle does not count it.
- Up mode: BCD increment with carries So->St->Mo->Mt->Ho->Ht, wrapping at 9/5/9/5/9/9. Reaching 99:59:59 moves to DONE and sets expired; there is no wrap.
- Down mode: BCD decrement with borrows. The tick that produces 00:00:00 moves to DONE and sets expired in the same cycle.
- DONE holds the count. expired stays set until clear on that channel.
- Display: disp_bcd, disp_state and disp_mode register the ch_sel-selected channel, with 1-cycle latency after a ch_sel or count change.
- running and expired are direct per-channel registers with no extra latency.

Decomposition:
- Package timer_pkg holds the state encoding, digit-limit constants (9, 5), BCD field index constants, and pure functions bcd_inc6 / bcd_dec6 / bcd_valid.
- Sub-module timer_channel holds one channel's FSM, count, preset and mode. It is instantiated NUM_CH times by a generate loop.
- The prescaler, command decode/fan-out, and display mux stay in the top.

Test Plan:
1. Reset mid-run (CLK_HZ=10): assert reset while ch0 is RUN at 00:00:07 -> all outputs 0 asynchronously; after release ch0 is IDLE at 000000.
2. Up carry: load 00:59:59 into ch0, mode=0, start -> disp_bcd=0x010000 one cycle after the next one_sec. Load 99:59:58 -> after 1 tick 995959, disp_state=DONE, expired[0]=1, later ticks hold.
3. Countdown: ch1 load 000002, mode=1, start -> 000001, then 000000 with DONE and expired[1]=1. Clear -> IDLE, count 000002, expired[1]=0. Zero preset with start -> DONE the next cycle.
4. Pause on tick: pause coincident with one_sec at 000004 -> 000005, then held across 5 ticks with running[0]=0. A second pause does nothing; start resumes to 000006 on the next tick.
5. Independence and display: ch0 counting up, ch_sel=2, load and start a countdown -> ch0 keeps counting. disp_bcd switches to ch2 exactly 1 cycle after the ch_sel change.
6. Load rejection: load 006000 -> load_err pulses, preset unchanged. Load while RUN -> load_ready=0, load_err pulses, count unaffected. clear+load+start in the same cycle -> only clear acts.
